rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Owns the single register-file write port; rf writes on negedge clk.
//  Arbitrates the write port between two sources: the in-order pipeline writeback (A)
//  and the multi-cycle mul/div result (B).
//  Keeps a busy scoreboard of registers awaiting a B result.
//  Raises a decode-stage stall for RAW and WAW hazards against those registers.
// PARAMETERS
//  NREG  32  number of architectural registers (x0 hardwired zero)
//  AW    5   register index width, clog2(NREG)
//  DW    32  data width
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous active-high reset
//  a_valid      in   1   pipeline WB has a result
//  a_rd         in   AW  destination of A
//  a_data       in   DW  data of A
//  a_ready      out  1   A accepted this cycle (0 => pipeline stalls WB)
//  b_valid      in   1   mul/div result available
//  b_rd         in   AW  destination of B
//  b_data       in   DW  data of B
//  b_ready      out  1   B accepted this cycle
//  iss_valid    in   1   decode issues a mul/div op
//  iss_rd       in   AW  destination of the issued op
//  iss_ready    out  1   issue allowed (0 if busy[iss_rd])
//  dec_rs1      in   AW  decode source 1
//  dec_rs2      in   AW  decode source 2
//  dec_rd       in   AW  decode destination
//  dec_use      in   3   {rd_wr, rs2_rd, rs1_rd} use flags
//  dec_stall    out  1   hazard: a used rs/rd is busy
//  RegWrite     out  1   to rf
//  Write_register  out  AW  to rf
//  Write_data      out  DW  to rf
// BEHAVIOUR
//  Reset values: RegWrite=0, Write_register=0, Write_data=0, busy=0, last_grant=A.
//   a_ready/b_ready/iss_ready/dec_stall are combinational; all are 0 during rst.
//  Arbitration: accept = valid & ready.
//   Only one valid -> it gets ready=1.
//   Both valid -> grant the source NOT in last_grant, so B wins the first conflict after reset.
//   last_grant updates only on a granted cycle.
//  Output stage: the accept in cycle N is registered.
//   RegWrite/Write_register/Write_data are valid throughout cycle N+1.
//   The rf captures the data at negedge of N+1.
//   RegWrite=0 when the accepted rd==0; the accept/ready handshake still completes.
//   Idle cycle -> RegWrite=0; Write_register/Write_data hold their last value.
//  Scoreboard busy[NREG-1:0]:
//   Set on iss_valid & iss_ready & iss_rd!=0.
//   Cleared at the posedge ending the cycle where B is accepted (busy[b_rd]<=0).
//   Set and clear on different rd in the same cycle -> both apply.
//   Set and clear on the same rd cannot occur: iss_ready uses the current busy.
//   busy[0] is always 0.
//   b_valid with busy[b_rd]==0 (protocol error) -> still written; simulation assertion fires.
//  Hazard:
//   dec_stall = (use[0]&busy[rs1]) | (use[1]&busy[rs2]) | (use[2]&busy[rd]).
//   No bypass from the output stage is needed: the negedge write in N+1 is visible
//   to the combinational rf read before the posedge ending N+1.
//   busy drops at the start of N+1.
//  Reset mid-operation: all busy bits clear and any pending output write is dropped.
//   An in-flight B result arriving after reset is accepted and written like a normal B result.
//   The protocol-error assertion is masked for 1 cycle after rst.
// STRUCTURE
//  rf_ctrl_pkg: AW/DW/NREG localparams, REG_X0=5'd0, grant encoding GNT_A=1'b0 / GNT_B=1'b1.
//  Sub-module rf_scoreboard: busy vector, set/clear ports, three query ports.
//  Top level: arbiter, last_grant flop, output registers.
// TESTING
//  1. A only: a_valid, rd=5, data=0x1234 -> a_ready=1; next cycle RegWrite=1, Write_register=5, data 0x1234.
//  2. Conflict after rst: A(rd=3) and B(rd=4) both valid for 2 cycles -> grants B then A; writes x4 then x3.
//  3. Scoreboard: issue rd=7 -> decode with rs1=7, use=001 -> dec_stall=1 until B(rd=7) is accepted;
//     stall=0 the next cycle; rf x7 holds the B data.
//  4. WAW: busy[9]=1, issue rd=9 -> iss_ready=0; dec_rd=9 with use[2] -> dec_stall=1.
//  5. x0: A rd=0 data=0xFFFF -> a_ready=1, RegWrite stays 0; issue rd=0 -> busy unchanged.
//  6. rst while busy=0x0000_0180 and a write is pending -> next cycle busy=0, RegWrite=0, dec_stall=0.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Imported by the interface, the scoreboard and the top level.
package rf_ctrl_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam logic [AW-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

endpackage

// File: rtl/rf_wb_if.sv
// Bundle of writeback, mul/div result, issue, decode and rf-port signals.
// master = the surrounding pipeline, slave = the scheduler.
interface rf_wb_if;
    import rf_ctrl_pkg::*;

    logic          a_valid;
    logic [AW-1:0] a_rd;
    logic [DW-1:0] a_data;
    logic          a_ready;

    logic          b_valid;
    logic [AW-1:0] b_rd;
    logic [DW-1:0] b_data;
    logic          b_ready;

    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;

    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic [AW-1:0] dec_rd;
    logic [2:0]    dec_use;
    logic          dec_stall;

    logic          RegWrite;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] Write_data;

    modport master (
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready,
        output iss_valid, iss_rd,
        input  iss_ready,
        output dec_rs1, dec_rs2, dec_rd, dec_use,
        input  dec_stall,
        input  RegWrite, Write_register, Write_data
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready,
        input  iss_valid, iss_rd,
        output iss_ready,
        input  dec_rs1, dec_rs2, dec_rd, dec_use,
        output dec_stall,
        output RegWrite, Write_register, Write_data
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bit per register awaiting a mul/div result.
// Set and clear on different registers in one cycle both take effect.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_rd,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_rd,
    input  logic [AW-1:0]   q1_rd,
    input  logic [AW-1:0]   q2_rd,
    input  logic [AW-1:0]   q3_rd,
    output logic            q1_busy,
    output logic            q2_busy,
    output logic            q3_busy,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q1_busy = busy_q[q1_rd];
    assign q2_busy = busy_q[q2_rd];
    assign q3_busy = busy_q[q3_rd];
    assign busy_o  = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Owns the rf write port: arbitrates pipeline WB (A) against mul/div (B),
// registers the winner for a negedge rf write, and raises decode hazards.
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
(
    input logic    clk,
    input logic    rst,
    rf_wb_if.slave bus
);

    grant_e          last_grant_q;
    grant_e          last_grant_d;
    wb_t             wb_q;
    wb_t             wb_d;
    logic            rst_q;

    logic            a_acc;
    logic            b_acc;
    logic            set_en;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;
    logic [NREG-1:0] busy;

    // Round-robin on conflict: the source that did not win last time goes.
    always_comb begin
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        if (!rst) begin
            bus.a_ready = bus.a_valid &
                          (!bus.b_valid || last_grant_q == GNT_B);
            bus.b_ready = bus.b_valid &
                          (!bus.a_valid || last_grant_q == GNT_A);
        end
    end

    assign a_acc = bus.a_valid & bus.a_ready;
    assign b_acc = bus.b_valid & bus.b_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        if (a_acc) begin
            last_grant_d = GNT_A;
        end else if (b_acc) begin
            last_grant_d = GNT_B;
        end
    end

    always_comb begin
        wb_d    = wb_q;
        wb_d.we = 1'b0;
        if (a_acc) begin
            wb_d.we   = (bus.a_rd != REG_X0);
            wb_d.rd   = bus.a_rd;
            wb_d.data = bus.a_data;
        end else if (b_acc) begin
            wb_d.we   = (bus.b_rd != REG_X0);
            wb_d.rd   = bus.b_rd;
            wb_d.data = bus.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_A;
            wb_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_q         <= wb_d;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign bus.RegWrite       = wb_q.we;
    assign bus.Write_register = wb_q.rd;
    assign bus.Write_data     = wb_q.data;

    assign set_en = bus.iss_valid & bus.iss_ready &
                    (bus.iss_rd != REG_X0);

    rf_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_rd  (bus.iss_rd),
        .clr_en  (b_acc),
        .clr_rd  (bus.b_rd),
        .q1_rd   (bus.dec_rs1),
        .q2_rd   (bus.dec_rs2),
        .q3_rd   (bus.dec_rd),
        .q1_busy (rs1_busy),
        .q2_busy (rs2_busy),
        .q3_busy (rd_busy),
        .busy_o  (busy)
    );

    assign bus.iss_ready = !rst & !busy[bus.iss_rd];

    // No bypass: the negedge rf write lands before decode samples.
    assign bus.dec_stall = !rst & ((bus.dec_use[0] & rs1_busy) |
                                   (bus.dec_use[1] & rs2_busy) |
                                   (bus.dec_use[2] & rd_busy));

    // A B result right after reset may belong to a dropped op.
    always_ff @(posedge clk) begin
        if (!rst && !rst_q && b_acc && bus.b_rd != REG_X0) begin
            assert (busy[bus.b_rd])
            else $error("rf_wb_scheduler: B result for idle x%0d",
                        bus.b_rd);
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed and randomized checks of rf_wb_scheduler against a
// set/queue-based reference model of the write-port rules.
module tb_rf_wb_scheduler;

    logic clk;
    logic rst;

    rf_wb_if bus ();

    rf_wb_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [32];
    always @(negedge clk) begin
        if (bus.RegWrite) rf[bus.Write_register] <= bus.Write_data;
    end

    int tests;
    int fails;

    // Reference model state
    bit          mb [32];
    int          mlast;
    bit          mwe;
    logic [4:0]  mwr;
    logic [31:0] mwd;

    // Combinational outputs observed in the last step
    logic o_ar, o_br, o_ir, o_st;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.a_valid   = 0;
        bus.a_rd      = 0;
        bus.a_data    = 0;
        bus.b_valid   = 0;
        bus.b_rd      = 0;
        bus.b_data    = 0;
        bus.iss_valid = 0;
        bus.iss_rd    = 0;
        bus.dec_rs1   = 0;
        bus.dec_rs2   = 0;
        bus.dec_rd    = 0;
        bus.dec_use   = 0;
    endtask

    // Called at posedge+1 with inputs set; returns at next posedge+1.
    task automatic step();
        bit ea, eb, ei, es;
        ea = 0; eb = 0; ei = 0; es = 0;
        if (!rst) begin
            ea = bus.a_valid && (!bus.b_valid || mlast == 1);
            eb = bus.b_valid && (!bus.a_valid || mlast == 0);
            ei = !mb[bus.iss_rd];
            es = (bus.dec_use[0] && mb[bus.dec_rs1]) ||
                 (bus.dec_use[1] && mb[bus.dec_rs2]) ||
                 (bus.dec_use[2] && mb[bus.dec_rd]);
        end
        #6;
        o_ar = bus.a_ready;
        o_br = bus.b_ready;
        o_ir = bus.iss_ready;
        o_st = bus.dec_stall;
        chk("a_ready", {31'd0, o_ar}, {31'd0, ea});
        chk("b_ready", {31'd0, o_br}, {31'd0, eb});
        chk("iss_ready", {31'd0, o_ir}, {31'd0, ei});
        chk("dec_stall", {31'd0, o_st}, {31'd0, es});
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (mb[i]) mb[i] = 0;
            mlast = 0;
            mwe = 0;
            mwr = 0;
            mwd = 0;
        end else begin
            if (ea) begin
                mlast = 0;
                mwe = (bus.a_rd != 0);
                mwr = bus.a_rd;
                mwd = bus.a_data;
            end else if (eb) begin
                mlast = 1;
                mwe = (bus.b_rd != 0);
                mwr = bus.b_rd;
                mwd = bus.b_data;
                mb[bus.b_rd] = 0;
            end else begin
                mwe = 0;
            end
            if (bus.iss_valid && ei && bus.iss_rd != 0) mb[bus.iss_rd] = 1;
        end
        chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, mwe});
        if (mwe || rst) begin
            chk("Write_register", {27'd0, bus.Write_register}, {27'd0, mwr});
            chk("Write_data", bus.Write_data, mwd);
        end
    endtask

    initial begin
        int q[$];
        foreach (rf[i]) rf[i] = 0;
        tests = 0;
        fails = 0;
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_we", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_wr", {27'd0, bus.Write_register}, 32'd0);
        chk("rst_wd", bus.Write_data, 32'd0);
        rst = 0;

        // Conflict right after reset: B first, then A
        bus.iss_valid = 1; bus.iss_rd = 4;
        step();
        idle();
        bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h33;
        bus.b_valid = 1; bus.b_rd = 4; bus.b_data = 32'h44;
        step();
        chk("t2_b_first", {31'd0, o_br}, 32'd1);
        chk("t2_wr_x4", {27'd0, bus.Write_register}, 32'd4);
        step();
        chk("t2_a_second", {31'd0, o_ar}, 32'd1);
        chk("t2_wr_x3", {27'd0, bus.Write_register}, 32'd3);
        idle();

        // A only
        bus.a_valid = 1; bus.a_rd = 5; bus.a_data = 32'h1234;
        step();
        chk("t1_ready", {31'd0, o_ar}, 32'd1);
        chk("t1_we", {31'd0, bus.RegWrite}, 32'd1);
        chk("t1_wr", {27'd0, bus.Write_register}, 32'd5);
        chk("t1_wd", bus.Write_data, 32'h1234);
        idle();
        step();
        chk("t1_rf5", rf[5], 32'h1234);

        // Scoreboard RAW
        bus.iss_valid = 1; bus.iss_rd = 7;
        step();
        idle();
        bus.dec_rs1 = 7; bus.dec_use = 3'b001;
        step();
        chk("t3_stall", {31'd0, o_st}, 32'd1);
        bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'hCAFE0007;
        step();
        chk("t3_stall_acc", {31'd0, o_st}, 32'd1);
        bus.b_valid = 0;
        step();
        chk("t3_stall_clr", {31'd0, o_st}, 32'd0);
        chk("t3_rf7", rf[7], 32'hCAFE0007);
        idle();

        // WAW
        bus.iss_valid = 1; bus.iss_rd = 9;
        step();
        bus.dec_rd = 9; bus.dec_use = 3'b100;
        step();
        chk("t4_iss_blocked", {31'd0, o_ir}, 32'd0);
        chk("t4_waw_stall", {31'd0, o_st}, 32'd1);
        idle();

        // x0
        bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 32'hFFFF;
        step();
        chk("t5_ready", {31'd0, o_ar}, 32'd1);
        chk("t5_no_we", {31'd0, bus.RegWrite}, 32'd0);
        idle();
        bus.iss_valid = 1; bus.iss_rd = 0;
        step();
        idle();
        bus.dec_rs1 = 0; bus.dec_use = 3'b001;
        step();
        chk("t5_x0_free", {31'd0, o_st}, 32'd0);
        idle();

        // Reset with busy bits and a pending write
        bus.iss_valid = 1; bus.iss_rd = 7;
        step();
        bus.iss_rd = 8;
        step();
        idle();
        bus.a_valid = 1; bus.a_rd = 12; bus.a_data = 32'h5A5A;
        step();
        chk("t6_pending", {31'd0, bus.RegWrite}, 32'd1);
        idle();
        rst = 1;
        step();
        rst = 0;
        chk("t6_we_drop", {31'd0, bus.RegWrite}, 32'd0);
        bus.dec_rs1 = 7; bus.dec_rs2 = 8; bus.dec_rd = 9;
        bus.dec_use = 3'b111;
        step();
        chk("t6_no_stall", {31'd0, o_st}, 32'd0);
        idle();

        // Randomized protocol-legal traffic
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int r = 1; r < 32; r++) if (mb[r]) q.push_back(r);
            rst = ($urandom_range(0, 79) == 0);
            bus.a_valid = $urandom_range(0, 1);
            bus.a_rd    = 5'($urandom_range(0, 31));
            bus.a_data  = $urandom;
            bus.b_valid = (q.size() != 0) && ($urandom_range(0, 2) != 0);
            bus.b_rd    = (q.size() != 0) ?
                          5'(q[$urandom_range(0, q.size() - 1)]) : 5'd0;
            bus.b_data  = $urandom;
            bus.iss_valid = $urandom_range(0, 1);
            bus.iss_rd  = 5'($urandom_range(0, 31));
            bus.dec_rs1 = 5'($urandom_range(0, 31));
            bus.dec_rs2 = 5'($urandom_range(0, 31));
            bus.dec_rd  = 5'($urandom_range(0, 31));
            bus.dec_use = 3'($urandom_range(0, 7));
            step();
        end
        rst = 0;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
